program_loader: RTL and testbench

Boot-time program loader: the receiving end of the LOAD-mode UART handshake that the execute stage drives. On `start` it sends the 0xAA ready byte to the host. It then receives a 32-bit big-endian word count followed by that many big-endian 32-bit instruction words from `uart_rx`, and writes them to instruction memory from word address 0 upward. It sits between `uart_rx`/`uart_tx` and the instruction BRAM write port, and hands control to EXEC mode once `done` is asserted.

---
 rtl/program_loader.sv | 172 +++++++++++++++++
 tb/tb_program_loader.sv | 440 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/program_loader.sv
// program_loader
//
// Boot-time loader for the LOAD-mode UART handshake. After a start pulse it
// sends the 0xAA ready byte to the host. It then receives a 32-bit big-endian
// word count, followed by that many big-endian 32-bit instruction words, and
// writes them into instruction memory from word address 0 upward.
//
// Ports:
//   clk, rst            single clock, synchronous active-high reset
//   start               one-cycle pulse; honoured only in IDLE, DONE or ERROR
//   rx_data/rx_ready    received byte and its one-cycle valid strobe
//   rx_ferr             framing error, qualified by rx_ready
//   tx_busy             transmitter busy
//   tx_data/tx_start    ready byte and its one-cycle transmit request
//   imem_we/addr/din    instruction memory write port, one cycle per word
//   word_count          number of words written so far
//   busy                high while handshaking or receiving
//   done / error        level status of the last load
module program_loader #(
    parameter int ADDR_WIDTH = 14,
    parameter int TIMEOUT    = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [7:0]            rx_data,
    input  logic                  rx_ready,
    input  logic                  rx_ferr,
    input  logic                  tx_busy,
    output logic [7:0]            tx_data,
    output logic                  tx_start,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [31:0]           imem_din,
    output logic [ADDR_WIDTH:0]   word_count,
    output logic                  busy,
    output logic                  done,
    output logic                  error
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_SEND_AA   = 3'd1;
    localparam logic [2:0] S_RECV_LEN  = 3'd2;
    localparam logic [2:0] S_RECV_DATA = 3'd3;
    localparam logic [2:0] S_DONE      = 3'd4;
    localparam logic [2:0] S_ERROR     = 3'd5;

    // Largest legal word count; needs one bit more than the address.
    localparam logic [32:0] CAPACITY = 33'd1 << ADDR_WIDTH;

    logic [2:0]          state;
    logic [1:0]          byte_idx;
    logic [23:0]         shift;
    logic [ADDR_WIDTH:0] length;
    logic [ADDR_WIDTH:0] word_idx;
    logic [31:0]         gap;

    logic [31:0] word_next;
    logic        byte_ok;
    logic        byte_bad;
    logic        last_byte;
    logic        timed_out;

    // The byte arriving now completes a word when three earlier bytes are
    // already held in the shift register.
    assign word_next = {shift, rx_data};
    assign byte_ok   = rx_ready && !rx_ferr;
    assign byte_bad  = rx_ready && rx_ferr;
    assign last_byte = (byte_idx == 2'd3);

    // gap holds the number of cycles since the last accepted strobe, so the
    // abort lands exactly TIMEOUT cycles after that strobe.
    assign timed_out = (TIMEOUT > 0) && !rx_ready && (gap + 32'd1 >= 32'(TIMEOUT));

    // The ready byte is requested combinationally so that tx_start is only
    // ever high in a cycle where the transmitter reports idle.
    assign tx_start   = (state == S_SEND_AA) && !tx_busy;
    assign tx_data    = tx_start ? 8'hAA : 8'h00;
    assign busy       = (state == S_SEND_AA) || (state == S_RECV_LEN) || (state == S_RECV_DATA);
    assign done       = (state == S_DONE);
    assign error      = (state == S_ERROR);
    assign word_count = word_idx;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            byte_idx  <= 2'd0;
            shift     <= 24'd0;
            length    <= '0;
            word_idx  <= '0;
            gap       <= 32'd0;
            imem_we   <= 1'b0;
            imem_addr <= '0;
            imem_din  <= 32'd0;
        end else begin
            imem_we <= 1'b0;
            case (state)
                S_IDLE, S_DONE, S_ERROR: begin
                    if (start) begin
                        state    <= S_SEND_AA;
                        byte_idx <= 2'd0;
                        word_idx <= '0;
                        gap      <= 32'd0;
                    end
                end

                // A byte that arrives together with the ready request is
                // taken as the first length byte.
                S_SEND_AA: begin
                    if (!tx_busy) begin
                        state <= S_RECV_LEN;
                        gap   <= 32'd0;
                        if (byte_bad) begin
                            state <= S_ERROR;
                        end else if (byte_ok) begin
                            shift    <= {shift[15:0], rx_data};
                            byte_idx <= 2'd1;
                            gap      <= 32'd1;
                        end
                    end
                end

                S_RECV_LEN: begin
                    if (byte_bad || timed_out) begin
                        state <= S_ERROR;
                    end else if (byte_ok) begin
                        gap      <= 32'd1;
                        shift    <= {shift[15:0], rx_data};
                        byte_idx <= byte_idx + 2'd1;
                        if (last_byte) begin
                            if (word_next == 32'd0) begin
                                state <= S_DONE;
                            end else if ({1'b0, word_next} > CAPACITY) begin
                                state <= S_ERROR;
                            end else begin
                                length <= word_next[ADDR_WIDTH:0];
                                state  <= S_RECV_DATA;
                            end
                        end
                    end else if (TIMEOUT > 0) begin
                        gap <= gap + 32'd1;
                    end
                end

                // word_idx already counts the word being written, so the
                // final write is the one that brings it up to length.
                S_RECV_DATA: begin
                    if (imem_we && (word_idx == length)) begin
                        state <= S_DONE;
                    end else if (byte_bad || timed_out) begin
                        state <= S_ERROR;
                    end else if (byte_ok) begin
                        gap      <= 32'd1;
                        shift    <= {shift[15:0], rx_data};
                        byte_idx <= byte_idx + 2'd1;
                        if (last_byte) begin
                            imem_we   <= 1'b1;
                            imem_addr <= word_idx[ADDR_WIDTH-1:0];
                            imem_din  <= word_next;
                            word_idx  <= word_idx + (ADDR_WIDTH+1)'(1);
                        end
                    end else if (TIMEOUT > 0) begin
                        gap <= gap + 32'd1;
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader
//
// Drives two loader instances from shared UART-side inputs: dut_a uses a
// 14-bit address and a 100-cycle timeout, dut_b a 4-bit address and no
// timeout. Only the selected instance is ever started, so the other one sits
// in IDLE, DONE or ERROR and ignores the byte traffic. A byte-level model of
// the protocol predicts every write, the done/error/busy levels and the final
// word count.
module tb_program_loader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       start_a;
    logic       start_b;
    logic [7:0] rx_data;
    logic       rx_ready;
    logic       rx_ferr;
    logic       tx_busy;

    logic [7:0]  a_tx_data;
    logic        a_tx_start;
    logic        a_we;
    logic [13:0] a_addr;
    logic [31:0] a_din;
    logic [14:0] a_wc;
    logic        a_busy;
    logic        a_done;
    logic        a_error;

    logic [7:0]  b_tx_data;
    logic        b_tx_start;
    logic        b_we;
    logic [3:0]  b_addr;
    logic [31:0] b_din;
    logic [4:0]  b_wc;
    logic        b_busy;
    logic        b_done;
    logic        b_error;

    program_loader #(.ADDR_WIDTH(14), .TIMEOUT(100)) dut_a (
        .clk        (clk),
        .rst        (rst),
        .start      (start_a),
        .rx_data    (rx_data),
        .rx_ready   (rx_ready),
        .rx_ferr    (rx_ferr),
        .tx_busy    (tx_busy),
        .tx_data    (a_tx_data),
        .tx_start   (a_tx_start),
        .imem_we    (a_we),
        .imem_addr  (a_addr),
        .imem_din   (a_din),
        .word_count (a_wc),
        .busy       (a_busy),
        .done       (a_done),
        .error      (a_error)
    );

    program_loader #(.ADDR_WIDTH(4), .TIMEOUT(0)) dut_b (
        .clk        (clk),
        .rst        (rst),
        .start      (start_b),
        .rx_data    (rx_data),
        .rx_ready   (rx_ready),
        .rx_ferr    (rx_ferr),
        .tx_busy    (tx_busy),
        .tx_data    (b_tx_data),
        .tx_start   (b_tx_start),
        .imem_we    (b_we),
        .imem_addr  (b_addr),
        .imem_din   (b_din),
        .word_count (b_wc),
        .busy       (b_busy),
        .done       (b_done),
        .error      (b_error)
    );

    // Observed outputs of whichever instance the current step targets.
    logic        sel;
    logic [7:0]  o_tx_data;
    logic        o_tx_start;
    logic        o_we;
    logic [13:0] o_addr;
    logic [31:0] o_din;
    logic [14:0] o_wc;
    logic        o_busy;
    logic        o_done;
    logic        o_error;

    always_comb begin
        if (sel) begin
            o_tx_data  = b_tx_data;
            o_tx_start = b_tx_start;
            o_we       = b_we;
            o_addr     = {10'd0, b_addr};
            o_din      = b_din;
            o_wc       = {10'd0, b_wc};
            o_busy     = b_busy;
            o_done     = b_done;
            o_error    = b_error;
        end else begin
            o_tx_data  = a_tx_data;
            o_tx_start = a_tx_start;
            o_we       = a_we;
            o_addr     = a_addr;
            o_din      = a_din;
            o_wc       = a_wc;
            o_busy     = a_busy;
            o_done     = a_done;
            o_error    = a_error;
        end
    end

    int n_checks;
    int n_fail;

    // Reference model of one load.
    logic [7:0]  stream[$];
    logic [31:0] m_word;
    longint      m_len;
    longint      m_cap;
    int          m_n;
    int          m_writes;
    int          m_since;
    int          m_timeout;
    int          done_in;
    int          err_in;
    logic        m_busy;
    logic        m_stop;
    logic        m_done;
    logic        m_error;
    logic        exp_we;
    logic [31:0] exp_addr;
    logic [31:0] exp_din;

    task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp)
        else begin
            n_fail++;
            $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        check_output({tag, " tx_data"},    32'(o_tx_data),  32'd0);
        check_output({tag, " tx_start"},   32'(o_tx_start), 32'd0);
        check_output({tag, " imem_we"},    32'(o_we),       32'd0);
        check_output({tag, " imem_addr"},  32'(o_addr),     32'd0);
        check_output({tag, " imem_din"},   o_din,           32'd0);
        check_output({tag, " word_count"}, 32'(o_wc),       32'd0);
        check_output({tag, " busy"},       32'(o_busy),     32'd0);
        check_output({tag, " done"},       32'(o_done),     32'd0);
        check_output({tag, " error"},      32'(o_error),    32'd0);
    endtask

    // Applies the protocol rules to one accepted strobe.
    task automatic model_byte(input logic [7:0] d, input logic fe);
        if (fe) begin
            m_stop = 1'b1;
            err_in = 1;
            return;
        end
        m_since = 0;
        m_n++;
        m_word = {m_word[23:0], d};
        if (m_n == 4) begin
            m_len = longint'(m_word);
            if (m_len == 0) begin
                m_stop  = 1'b1;
                done_in = 1;
            end else if (m_len > m_cap) begin
                m_stop = 1'b1;
                err_in = 1;
            end
        end else if (m_n > 4 && (m_n % 4) == 0) begin
            exp_we   = 1'b1;
            exp_addr = 32'(m_n / 4 - 2);
            exp_din  = m_word;
            m_writes++;
            if (longint'(m_writes) == m_len) begin
                m_stop  = 1'b1;
                done_in = 2;
            end
        end
    endtask

    // One clock cycle: drive the UART inputs, compare this cycle's outputs
    // with the model, then let the model see the inputs.
    task automatic run_cycle(input logic rdy, input logic [7:0] d, input logic fe);
        rx_ready = rdy;
        rx_data  = d;
        rx_ferr  = fe;
        @(negedge clk);
        check_output("imem_we", 32'(o_we), 32'(exp_we));
        if (exp_we) begin
            check_output("imem_addr", 32'(o_addr), exp_addr);
            check_output("imem_din", o_din, exp_din);
        end
        check_output("done", 32'(o_done), 32'(m_done));
        check_output("error", 32'(o_error), 32'(m_error));
        check_output("busy", 32'(o_busy), 32'(m_busy));
        exp_we = 1'b0;
        if (m_busy && !m_stop) begin
            if (rdy) begin
                model_byte(d, fe);
            end else if (m_timeout > 0) begin
                m_since++;
                if (m_since >= m_timeout - 1) begin
                    m_stop = 1'b1;
                    err_in = 1;
                end
            end
        end
        if (done_in > 0) begin
            done_in--;
            if (done_in == 0) begin
                m_done = 1'b1;
                m_busy = 1'b0;
            end
        end
        if (err_in > 0) begin
            err_in--;
            if (err_in == 0) begin
                m_error = 1'b1;
                m_busy  = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        rx_ready = 1'b0;
        rx_ferr  = 1'b0;
        rx_data  = 8'h00;
        start_a  = 1'b0;
        start_b  = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) run_cycle(1'b0, 8'h00, 1'b0);
    endtask

    task automatic push_word(input logic [31:0] w);
        stream.push_back(w[31:24]);
        stream.push_back(w[23:16]);
        stream.push_back(w[15:8]);
        stream.push_back(w[7:0]);
    endtask

    // Pulses start on the selected instance, holds tx_busy for busy_cycles,
    // and checks that the ready byte goes out only once the transmitter frees.
    task automatic start_load(input logic which, input int busy_cycles);
        sel       = which;
        m_cap     = which ? 64'd16 : 64'd16384;
        m_timeout = which ? 0 : 100;
        m_word    = 32'd0;
        m_len     = -1;
        m_n       = 0;
        m_writes  = 0;
        m_since   = 0;
        done_in   = -1;
        err_in    = -1;
        m_stop    = 1'b0;
        m_done    = 1'b0;
        m_error   = 1'b0;
        m_busy    = 1'b0;
        exp_we    = 1'b0;
        stream.delete();
        if (which) start_b = 1'b1;
        else       start_a = 1'b1;
        tx_busy = (busy_cycles > 0);
        @(posedge clk);
        #1;
        start_a = 1'b0;
        start_b = 1'b0;
        for (int i = 0; i < busy_cycles; i++) begin
            @(negedge clk);
            check_output("tx_start while tx_busy", 32'(o_tx_start), 32'd0);
            check_output("busy in handshake", 32'(o_busy), 32'd1);
            @(posedge clk);
            #1;
        end
        tx_busy = 1'b0;
        @(negedge clk);
        check_output("tx_start", 32'(o_tx_start), 32'd1);
        check_output("tx_data", 32'(o_tx_data), 32'h0000_00AA);
        check_output("done cleared by start", 32'(o_done), 32'd0);
        check_output("error cleared by start", 32'(o_error), 32'd0);
        @(posedge clk);
        #1;
        m_busy = 1'b1;
    endtask

    // Sends the queued stream, optionally flagging one byte as a framing
    // error and pulsing start (which must be ignored) at one byte.
    task automatic apply_stimulus(input int ferr_at, input int max_gap, input int start_at);
        for (int j = 0; j < stream.size(); j++) begin
            if (j == start_at) begin
                if (sel) start_b = 1'b1;
                else     start_a = 1'b1;
            end
            run_cycle(1'b1, stream[j], (j == ferr_at));
            if (max_gap > 0) repeat ($urandom_range(max_gap)) run_cycle(1'b0, 8'h00, 1'b0);
        end
    endtask

    task automatic pulse_reset(input logic rdy, input logic [7:0] d, input string tag);
        rx_ready = rdy;
        rx_data  = d;
        rst      = 1'b1;
        @(posedge clk);
        #1;
        rx_ready = 1'b0;
        rx_data  = 8'h00;
        rst      = 1'b0;
        @(negedge clk);
        check_zero(tag);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n_words;

        n_checks = 0;
        n_fail   = 0;
        sel      = 1'b0;
        rst      = 1'b1;
        start_a  = 1'b0;
        start_b  = 1'b0;
        rx_ready = 1'b0;
        rx_data  = 8'h00;
        rx_ferr  = 1'b0;
        tx_busy  = 1'b0;
        exp_we   = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_zero("reset a");
        sel = 1'b1;
        #1;
        check_zero("reset b");
        @(posedge clk);
        #1;

        // Normal load, back-to-back bytes.
        start_load(1'b0, 0);
        push_word(32'd3);
        push_word(32'h1234_5678);
        push_word(32'hDEAD_BEEF);
        push_word(32'h0000_0001);
        apply_stimulus(-1, 0, -1);
        idle(3);
        check_output("normal word_count", 32'(o_wc), 32'd3);

        // Zero length.
        start_load(1'b0, 0);
        push_word(32'd0);
        apply_stimulus(-1, 0, -1);
        idle(3);
        check_output("zero word_count", 32'(o_wc), 32'd0);

        // Random load with a busy transmitter, random gaps and a start pulse
        // that arrives mid-load.
        start_load(1'b0, 3);
        n_words = $urandom_range(6, 2);
        push_word(32'(n_words));
        for (int i = 0; i < n_words; i++) push_word($urandom);
        apply_stimulus(-1, 3, 6);
        idle(4);
        check_output("random word_count", 32'(o_wc), 32'(n_words));

        // Capacity with a 4-bit address: one past capacity is rejected.
        start_load(1'b1, 0);
        push_word(32'd17);
        apply_stimulus(-1, 0, -1);
        idle(3);
        check_output("over capacity word_count", 32'(o_wc), 32'd0);

        // Exactly full capacity.
        start_load(1'b1, 1);
        push_word(32'd16);
        for (int i = 0; i < 16; i++) push_word($urandom);
        apply_stimulus(-1, 1, -1);
        idle(3);
        check_output("full capacity word_count", 32'(o_wc), 32'd16);

        // Framing error on the 2nd byte of word 1; later bytes are ignored.
        start_load(1'b0, 0);
        push_word(32'd3);
        for (int i = 0; i < 3; i++) push_word($urandom);
        apply_stimulus(9, 1, -1);
        idle(3);
        check_output("framing word_count", 32'(o_wc), 32'd1);

        // Timeout after two of eight data bytes.
        start_load(1'b0, 0);
        push_word(32'd2);
        stream.push_back(8'h5A);
        stream.push_back(8'hC3);
        apply_stimulus(-1, 0, -1);
        idle(105);
        check_output("timeout word_count", 32'(o_wc), 32'd0);

        // Reset after five data bytes, then a one-word reload.
        start_load(1'b0, 0);
        push_word(32'd2);
        for (int i = 0; i < 5; i++) stream.push_back(8'($urandom));
        apply_stimulus(-1, 0, -1);
        pulse_reset(1'b0, 8'h00, "mid-load rst");
        start_load(1'b0, 0);
        push_word(32'd1);
        push_word($urandom);
        apply_stimulus(-1, 1, -1);
        idle(3);
        check_output("reload word_count", 32'(o_wc), 32'd1);

        // Reset arriving with the byte that completes a word.
        start_load(1'b1, 0);
        push_word(32'd2);
        stream.push_back(8'h11);
        stream.push_back(8'h22);
        stream.push_back(8'h33);
        apply_stimulus(-1, 0, -1);
        pulse_reset(1'b1, 8'h44, "rst with 4th byte");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
